// File: rtl/conv_stream_driver_pkg.sv
// rtl/conv_stream_driver_pkg.sv - sizes, state type and helpers shared by conv_stream_driver
`timescale 1ns/1ps
package conv_drv_pkg;
  localparam int DATA_WIDTH_X = 8;
  localparam int DATA_WIDTH_F = 8;
  localparam int X_SIZE       = 128;
  localparam int F_SIZE       = 32;
  localparam int ACC_SIZE     = 21;
  localparam int SUM_WIDTH    = 28;

  localparam int Y_SIZE = X_SIZE - F_SIZE + 1;
  localparam int XA_W   = $clog2(X_SIZE);
  localparam int FA_W   = $clog2(F_SIZE);
  localparam int YA_W   = $clog2(Y_SIZE);
  localparam int YC_W   = $clog2(Y_SIZE + 1);
  localparam int WR_W   = (DATA_WIDTH_X > DATA_WIDTH_F) ? DATA_WIDTH_X : DATA_WIDTH_F;

  localparam logic [YC_W-1:0] Y_CNT_FULL = YC_W'(Y_SIZE);
  localparam logic [YA_W-1:0] Y_ADDR_END = YA_W'(Y_SIZE);
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  function automatic logic [SUM_WIDTH-1:0] sext_y(input logic [ACC_SIZE-1:0] v);
    return {{(SUM_WIDTH - ACC_SIZE){v[ACC_SIZE-1]}}, v};
  endfunction
endpackage

// File: rtl/conv_stream_driver_stream_src_chan.sv
// rtl/conv_stream_driver_stream_src_chan.sv - one valid/ready source channel walking a DEPTH-word buffer
`timescale 1ns/1ps
module stream_src_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     active,
  input  logic                     throttle,
  input  logic [WIDTH-1:0]         load_word,
  input  logic [WIDTH-1:0]         word,
  output logic [$clog2(DEPTH)-1:0] addr,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     finished
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] cnt;
  logic          xfer;
  logic          may_start;

  assign xfer      = m_valid && m_ready;
  assign may_start = active && throttle;
  // word to present next: the one after the current beat, or the pending one when idle
  assign addr      = m_valid ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      finished <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      m_valid  <= 1'b1;
      m_data   <= load_word;
      finished <= 1'b0;
    end else if (xfer) begin
      if (cnt == LAST) begin
        m_valid  <= 1'b0;
        finished <= 1'b1;
      end else begin
        cnt     <= cnt + 1'b1;
        m_valid <= may_start;
        if (may_start) m_data <= word;
      end
    end else if (!m_valid && !finished && may_start) begin
      m_valid <= 1'b1;
      m_data  <= word;
    end
  end
endmodule

// File: rtl/conv_stream_driver.sv
// rtl/conv_stream_driver.sv - X/F stream master and Y collector; CONV_DRIVER_THROTTLE_EN adds LFSR bubbles
`timescale 1ns/1ps
module conv_stream_driver
  import conv_drv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [XA_W-1:0]         wr_addr,
  input  logic [WR_W-1:0]         wr_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    m_valid_x,
  input  logic                    m_ready_x,
  output logic [DATA_WIDTH_X-1:0] m_data_x,
  output logic                    m_valid_f,
  input  logic                    m_ready_f,
  output logic [DATA_WIDTH_F-1:0] m_data_f,
  input  logic                    s_valid_y,
  output logic                    s_ready_y,
  input  logic [ACC_SIZE-1:0]     s_data_y,
  input  logic [YA_W-1:0]         rd_addr,
  output logic [ACC_SIZE-1:0]     rd_data,
  output logic [SUM_WIDTH-1:0]    y_sum
);
  logic [DATA_WIDTH_X-1:0] xbuf [X_SIZE];
  logic [DATA_WIDTH_F-1:0] fbuf [F_SIZE];
  logic [ACC_SIZE-1:0]     ybuf [Y_SIZE];

  state_t          state;
  logic [YC_W-1:0] y_cnt;
  logic [YC_W-1:0] y_cnt_nxt;
  logic            start_ok, wr_ok, y_xfer, streaming;
  logic            x_thr, f_thr, y_thr;
  logic            x_fin, f_fin;
  logic [XA_W-1:0] x_addr;
  logic [FA_W-1:0] f_addr;
  logic [DATA_WIDTH_X-1:0] x_first;
  logic [DATA_WIDTH_F-1:0] f_first;

  assign start_ok  = (state == IDLE) && start;
  assign wr_ok     = (state == IDLE) && wr_en;
  assign streaming = (state == STREAM);
  assign y_xfer    = s_valid_y && s_ready_y;
  assign y_cnt_nxt = y_cnt + YC_W'(y_xfer);

  // a write landing on word 0 in the start cycle must be the first beat streamed
  assign x_first = (wr_ok && !wr_sel && wr_addr == '0) ? wr_data[DATA_WIDTH_X-1:0] : xbuf[0];
  assign f_first = (wr_ok && wr_sel && wr_addr[FA_W-1:0] == '0) ? wr_data[DATA_WIDTH_F-1:0] : fbuf[0];

`ifdef CONV_DRIVER_THROTTLE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else if (busy) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign x_thr = lfsr[0];
  assign f_thr = lfsr[5];
  assign y_thr = lfsr[10];
`else
  assign x_thr = 1'b1;
  assign f_thr = 1'b1;
  assign y_thr = 1'b1;
`endif

  stream_src_chan #(.WIDTH(DATA_WIDTH_X), .DEPTH(X_SIZE)) u_chan_x (
    .clk(clk), .reset(reset), .load(start_ok), .active(streaming), .throttle(x_thr),
    .load_word(x_first), .word(xbuf[x_addr]), .addr(x_addr),
    .m_valid(m_valid_x), .m_ready(m_ready_x), .m_data(m_data_x), .finished(x_fin)
  );

  stream_src_chan #(.WIDTH(DATA_WIDTH_F), .DEPTH(F_SIZE)) u_chan_f (
    .clk(clk), .reset(reset), .load(start_ok), .active(streaming), .throttle(f_thr),
    .load_word(f_first), .word(fbuf[f_addr]), .addr(f_addr),
    .m_valid(m_valid_f), .m_ready(m_ready_f), .m_data(m_data_f), .finished(f_fin)
  );

  always_ff @(posedge clk) begin
    if (wr_ok && !wr_sel) xbuf[wr_addr] <= wr_data[DATA_WIDTH_X-1:0];
    if (wr_ok && wr_sel)  fbuf[wr_addr[FA_W-1:0]] <= wr_data[DATA_WIDTH_F-1:0];
    if (y_xfer)           ybuf[y_cnt[YA_W-1:0]] <= s_data_y;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      s_ready_y <= 1'b0;
      y_cnt     <= '0;
      y_sum     <= '0;
    end else begin
      done <= 1'b0;
      if (y_xfer) begin
        y_cnt <= y_cnt_nxt;
        y_sum <= y_sum + sext_y(s_data_y);
      end
      case (state)
        IDLE: if (start) begin
          state     <= STREAM;
          busy      <= 1'b1;
          y_cnt     <= '0;
          y_sum     <= '0;
          s_ready_y <= y_thr;
        end
        STREAM: begin
          s_ready_y <= y_thr && (y_cnt_nxt != Y_CNT_FULL);
          if (x_fin && f_fin && y_cnt == Y_CNT_FULL) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            s_ready_y <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data = (rd_addr < Y_ADDR_END) ? ybuf[rd_addr] : '0;
endmodule

// File: tb/tb_conv_stream_driver.sv
// tb/tb_conv_stream_driver.sv - scoreboard bench for conv_stream_driver
`timescale 1ns/1ps
module tb_conv_stream_driver;
  import conv_drv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0, wr_sel = 1'b0;
  logic [XA_W-1:0] wr_addr = '0;
  logic [WR_W-1:0] wr_data = '0;
  logic start = 1'b0;
  logic busy, done;
  logic m_valid_x, m_valid_f, s_ready_y;
  logic m_ready_x = 1'b1, m_ready_f = 1'b1, s_valid_y = 1'b0;
  logic [DATA_WIDTH_X-1:0] m_data_x;
  logic [DATA_WIDTH_F-1:0] m_data_f;
  logic [ACC_SIZE-1:0] s_data_y = '0;
  logic [YA_W-1:0] rd_addr = '0;
  logic [ACC_SIZE-1:0] rd_data;
  logic [SUM_WIDTH-1:0] y_sum;

  conv_stream_driver dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done),
    .m_valid_x(m_valid_x), .m_ready_x(m_ready_x), .m_data_x(m_data_x),
    .m_valid_f(m_valid_f), .m_ready_f(m_ready_f), .m_data_f(m_data_f),
    .s_valid_y(s_valid_y), .s_ready_y(s_ready_y), .s_data_y(s_data_y),
    .rd_addr(rd_addr), .rd_data(rd_data), .y_sum(y_sum)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [7:0] mx [X_SIZE];
  logic [7:0] mf [F_SIZE];
  logic [7:0] qx [$];
  logic [7:0] qf [$];
  logic [ACC_SIZE-1:0] qy [$];
  logic [SUM_WIDTH-1:0] exp_sum = '0;
  int x_beats = 0, f_beats = 0, y_idx = 0, done_cnt = 0, cyc = 0;
  int x_first = 0, x_last = 0, cur_stall_at = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sinks and Y scoreboard push, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      check("done_x_beats", x_beats, X_SIZE);
      check("done_y_count", y_idx, Y_SIZE);
    end
    if (m_valid_x && m_ready_x) begin
      if (x_beats == 0) x_first = cyc;
      if (x_beats == X_SIZE - 1) x_last = cyc;
      if (qx.size() == 0) check("x_extra_beat", 1, 0);
      else check("x_data", m_data_x, qx.pop_front());
      x_beats++;
    end
    if (m_valid_f && m_ready_f) begin
      if (qf.size() == 0) check("f_extra_beat", 1, 0);
      else check("f_data", m_data_f, qf.pop_front());
      f_beats++;
    end
    if (s_valid_y && s_ready_y) begin
      qy.push_back(s_data_y);
      exp_sum = exp_sum + SUM_WIDTH'(int'($signed(s_data_y)));
      y_idx++;
    end else if (s_valid_y && y_idx >= Y_SIZE) begin
      check("y_extra_ready", s_ready_y, 0);
    end
    if (cur_stall_at >= 0 && x_beats == cur_stall_at && !m_ready_x) begin
      check("stall_valid", m_valid_x, 1);
      check("stall_data", m_data_x, mx[cur_stall_at]);
    end
  end

  task automatic load_bufs(input bit rnd);
    for (int i = 0; i < X_SIZE; i++) begin
      mx[i] = rnd ? 8'($urandom) : 8'(i);
      if (i == 0 && mx[i] == 8'hFF) mx[i] = 8'h7E;
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = XA_W'(i); wr_data = mx[i];
      @(posedge clk); #1;
    end
    for (int j = 0; j < F_SIZE; j++) begin
      mf[j] = rnd ? 8'(3 * j + 1) : 8'd1;
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = XA_W'(j); wr_data = mf[j];
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic do_run(input int stall_at, input int stall_len, input bit stall_until_y,
                        input int y_limit, input bit y_neg, input int poke_at, input int reset_at);
    int stall_ctr = 0;
    bit stalling;
    qx.delete(); qf.delete(); qy.delete();
    for (int i = 0; i < X_SIZE; i++) qx.push_back(mx[i]);
    for (int j = 0; j < F_SIZE; j++) qf.push_back(mf[j]);
    x_beats = 0; f_beats = 0; y_idx = 0; done_cnt = 0; exp_sum = '0;
    cur_stall_at = stall_at;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start   = (c == poke_at);
      wr_en   = (c == poke_at);
      wr_sel  = 1'b0; wr_addr = '0; wr_data = 8'hFF;
      if (reset_at >= 0 && x_beats == reset_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_valid_x", m_valid_x, 0);
        check("rst_valid_f", m_valid_f, 0);
        check("rst_ready_y", s_ready_y, 0);
        check("rst_busy", busy, 0);
        s_valid_y = 1'b0; m_ready_x = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_done", done_cnt, 0);
        check("rst_idle_valid", m_valid_x, 0);
        return;
      end
      stalling = (stall_at >= 0) && (x_beats == stall_at) &&
                 (stall_until_y ? (y_idx < Y_SIZE) : (stall_ctr < stall_len));
      m_ready_x = !stalling;
      if (stalling) stall_ctr++;
      s_valid_y = (y_idx < y_limit);
      s_data_y  = y_neg ? ACC_SIZE'(-(y_idx + 1)) : ACC_SIZE'(y_idx + 5);
      if (done_cnt > 0) break;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    s_valid_y = 1'b0; m_ready_x = 1'b1; wr_en = 1'b0; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("x_beats", x_beats, X_SIZE);
    check("f_beats", f_beats, F_SIZE);
    check("y_count", y_idx, Y_SIZE);
    check("qx_empty", qx.size(), 0);
    check("done_once", done_cnt, 1);
    check("busy_after", busy, 0);
    check("y_sum", y_sum, exp_sum);
    if (stall_at >= 0 && !stall_until_y) check("stall_len", stall_ctr, stall_len);
    for (int k = 0; k < Y_SIZE; k++) begin
      rd_addr = YA_W'(k);
      #1;
      if (qy.size() > 0) check("rd_data", rd_data, qy.pop_front());
      else check("rd_missing", k, Y_SIZE);
    end
    rd_addr = YA_W'(Y_SIZE); #1;
    check("rd_oob", rd_data, 0);
    rd_addr = '1; #1;
    check("rd_oob_max", rd_data, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid_x", m_valid_x, 0);
    check("reset_valid_f", m_valid_f, 0);
    check("reset_ready_y", s_ready_y, 0);
    check("reset_data_x", m_data_x, 0);
    check("reset_data_f", m_data_f, 0);
    check("reset_y_sum", y_sum, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    load_bufs(1'b0);
    do_run(-1, 0, 1'b0, Y_SIZE, 1'b0, -1, -1);
    check("x_consecutive", x_last - x_first, X_SIZE - 1);
    rd_addr = 7'd96; #1;
    check("rd_96", rd_data, 101);
    check("y_sum_total", y_sum, 5141);

    do_run(40, 10, 1'b0, Y_SIZE, 1'b0, -1, -1);

    load_bufs(1'b1);
    do_run(50, 0, 1'b1, Y_SIZE, 1'b1, -1, -1);

    do_run(-1, 0, 1'b0, Y_SIZE + 1, 1'b0, -1, -1);

    do_run(-1, 0, 1'b0, Y_SIZE, 1'b0, 20, -1);
    do_run(-1, 0, 1'b0, Y_SIZE, 1'b0, -1, -1);

    do_run(-1, 0, 1'b0, Y_SIZE, 1'b0, -1, 60);
    do_run(-1, 0, 1'b0, Y_SIZE, 1'b1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_stream_driver.md
Name: conv_stream_driver

Overview:
Master-side counterpart of the convolution engine's stream interface. It holds host-loaded X (128) and F (32) sample buffers. On start it streams both buffers out on two independent valid/ready master channels. It collects the returned Y results on a valid/ready slave channel into a result buffer that the host can read back. It is used as the on-chip stimulus/response engine in front of the conv datapath.

Parameters:
DATA_WIDTH_X, 8, width of X samples
DATA_WIDTH_F, 8, width of F samples
X_SIZE, 128, X samples per run
F_SIZE, 32, F coefficients per run
ACC_SIZE, 21, width of Y results
SUM_WIDTH, 28, width of running Y checksum (wraps)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
wr_en  in  1  host buffer write strobe
wr_sel  in  1  0 = X buffer, 1 = F buffer
wr_addr  in  $clog2(X_SIZE)  write address (F uses low $clog2(F_SIZE) bits)
wr_data  in  max(DATA_WIDTH_X,DATA_WIDTH_F)  write data (low bits used)
start  in  1  run request
busy  out  1  run in progress
done  out  1  one-cycle pulse at run completion
m_valid_x / m_ready_x / m_data_x  out/in/out  1/1/DATA_WIDTH_X  X master channel
m_valid_f / m_ready_f / m_data_f  out/in/out  1/1/DATA_WIDTH_F  F master channel
s_valid_y / s_ready_y / s_data_y  in/out/in  1/1/ACC_SIZE  Y slave channel
rd_addr  in  $clog2(Y_SIZE)  result read address
rd_data  out  ACC_SIZE  result word, combinational read
y_sum  out  SUM_WIDTH  wrapping sum of Y received in last/current run

Behaviour:
- Y_SIZE = X_SIZE-F_SIZE+1 (97). A transfer occurs on a posedge where valid && ready.
- Reset values: busy=0, done=0, all m_valid=0, s_ready_y=0, m_data_x/f=0, y_sum=0, counters=0, FSM=IDLE. Buffer contents are not reset.
- FSM IDLE: host writes accepted; start=1 -> STREAM. On the same edge: x_cnt, f_cnt and y_cnt clear; y_sum clears; busy=1. m_valid_x and m_valid_f rise in the next cycle with word 0. s_ready_y=1 from that cycle.
- STREAM: each channel runs independently. m_data = buf[cnt]. On a transfer, cnt++ and data presents buf[cnt+1] next cycle. valid deasserts on the cycle after the last word (X_SIZE-1 / F_SIZE-1) transfers.
- STREAM AXI rules: once valid=1, valid and data hold stable until ready. A channel never deasserts valid without a transfer.
- Y side: on a transfer, ybuf[y_cnt] <= s_data_y; y_sum += sign-extended s_data_y, wrapping at SUM_WIDTH; y_cnt++. s_ready_y drops the cycle after the Y_SIZE-th word. Extra Y words are not accepted.
- Y may arrive before X/F streaming ends (overlapped execution). This is legal.
- STREAM -> DONE when x sent = X_SIZE, f sent = F_SIZE, and y received = Y_SIZE. Any order of completion is allowed.
- DONE: done=1 for exactly one cycle, busy=0, -> IDLE.
- start while busy: ignored. wr_en while busy: ignored (buffers frozen). start and wr_en in the same IDLE cycle: the write lands and start is accepted. The stream uses the written value if it targets word 0.
- rd_addr ≥ Y_SIZE returns 0. rd_data is valid any time; it reflects partial results mid-run.
- Asynchronous reset mid-run: all valids/readies drop immediately and the FSM returns to IDLE. No done pulse.

Optional Feature:
CONV_DRIVER_THROTTLE_EN: a 16-bit LFSR (seed 16'hACE1, advanced every cycle while busy) gates the channels.
- With the macro: each channel's "may start a new beat" and s_ready_y are qualified by distinct LFSR bits, giving random bubbles and backpressure. A beat already presented is never withdrawn.
- Without the macro: channels present data and readiness every eligible cycle, with no gating logic present.

Decomposition:
- Package conv_drv_pkg: DATA_WIDTH_X/F, X_SIZE, F_SIZE, ACC_SIZE, derived Y_SIZE and address widths, state enum typedef {IDLE, STREAM, DONE}, LFSR seed constant.
- One natural sub-module: stream_src_chan (parameterised width/depth; counter, valid register, last-beat detect, optional throttle input). Instantiated twice, for X and F.

Test Plan:
- Load X[i]=i (mod 256), F[j]=1. Start with all readies=1 and the bench echoing Y[k]=k+5 immediately. Required: 128 X beats in 128 consecutive cycles, 32 F beats, rd_data(96)=101, y_sum=5141, one done pulse, busy low after.
- Hold m_ready_x=0 for 10 cycles at beat 40. Required: m_valid_x=1 and m_data_x=40 stable throughout; next beat is 41.
- Bench returns Y[0..96] while X is only at beat 50. Required: all Y accepted, done only after X beat 127 transfers.
- Bench offers a 98th Y word. Required: s_ready_y=0, ybuf and y_sum unchanged, done still fires.
- Pulse start at cycle 20 of a run, and wr_en to X[0]=0xFF while busy. Required: no restart, X[0] unchanged on the next run.
- Assert reset at X beat 60. Required: valids/ready drop asynchronously, no done. A new start streams from beat 0.
